// File: rtl/lsu_pkg.sv
// lsu_pkg: shared access-size/state enums and the misalignment check for the LSU
package lsu_pkg;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_ILL = 2'b11} size_e;
  typedef enum logic {ST_IDLE = 1'b0, ST_WRITE = 1'b1} state_e;
  function automatic logic misaligned(input size_e s, input logic [1:0] a);
    return (s == SZ_HALF && a[0]) || (s == SZ_WORD && a != 2'b00) || s == SZ_ILL;
  endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: byte/half lane extract+extend for loads and lane merge for stores (word in, word/ld/st out)
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  a,
  input  size_e       size,
  input  logic        uns,
  input  logic [31:0] wdata,
  output logic [31:0] ld,
  output logic [31:0] st
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b  = word[{a, 3'b000} +: 8];
    h  = word[{a[1], 4'b0000} +: 16];
    ld = size == SZ_BYTE ? {{24{~uns & b[7]}}, b} :
         size == SZ_HALF ? {{16{~uns & h[15]}}, h} : word;
    st = wdata;
    if (size == SZ_BYTE) begin
      st = word;
      st[{a, 3'b000} +: 8] = wdata[7:0];
    end else if (size == SZ_HALF) begin
      st = word;
      st[{a[1], 4'b0000} +: 16] = wdata[15:0];
    end
  end
endmodule

// File: rtl/lsu_subword_rmw.sv
// lsu_subword_rmw: MEM-stage load/store front-end; zero-latency loads, 1-cycle word stores, 2-cycle sub-word RMW stores
module lsu_subword_rmw
  import lsu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic [DATA_W-1:0] load_data,
  output logic              misalign_err,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);
  state_e                state, state_n;
  size_e                 size, size_q;
  logic [DATA_W-1:0]     rd_q, wdata_q;
  logic [DEPTH_LOG2+1:0] addr_q;
  logic                  idle, go;
  logic [DATA_W-1:0]     al_ld, al_st;
  assign size = size_e'(req_size);
  assign idle = state == ST_IDLE;
  assign go   = idle && req_valid && !misaligned(size, req_addr[1:0]);
  assign mem_a = DATA_W'(idle ? req_addr[DEPTH_LOG2+1:2] : addr_q[DEPTH_LOG2+1:2]);
  // One aligner serves both paths: live request in IDLE, latched RMW context in WRITE.
  lsu_lane_align u_align (
    .word  (idle ? mem_rd : rd_q),
    .a     (idle ? req_addr[1:0] : addr_q[1:0]),
    .size  (idle ? size : size_q),
    .uns   (req_unsigned),
    .wdata (idle ? req_wdata : wdata_q),
    .ld    (al_ld),
    .st    (al_st)
  );
  assign mem_wd = al_st;
  always_comb begin
    state_n   = state;
    stall     = 1'b0;
    mem_we    = 1'b0;
    load_data = '0;
    if (!idle) begin
      mem_we  = !RST;
      state_n = ST_IDLE;
    end else if (go && req_we && size == SZ_WORD) mem_we = 1'b1;
    else if (go && req_we) begin
      stall   = 1'b1;
      state_n = ST_WRITE;
    end else if (go) load_data = al_ld;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= ST_IDLE;
      misalign_err <= 1'b0;
      rd_q         <= '0;
      addr_q       <= '0;
      size_q       <= SZ_BYTE;
      wdata_q      <= '0;
    end else begin
      state        <= state_n;
      misalign_err <= idle && req_valid && misaligned(size, req_addr[1:0]);
      if (idle && state_n == ST_WRITE) begin
        rd_q    <= mem_rd;
        addr_q  <= req_addr[DEPTH_LOG2+1:0];
        size_q  <= size;
        wdata_q <= req_wdata;
      end
    end
  end
endmodule

// File: tb/tb_lsu_subword_rmw.sv
// tb_lsu_subword_rmw: directed self-checking bench with a word-addressed memory model
module tb_lsu_subword_rmw;
  import lsu_pkg::*;
  logic        CLK = 1'b0, RST = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        stall, misalign_err, mem_we;
  logic [31:0] load_data, mem_a, mem_wd, mem_rd;
  logic [31:0] mem [64];
  logic        pl_we = 1'b0;
  logic [5:0]  pl_a = '0;
  logic [31:0] pl_d = '0;
  int checks = 0, errors = 0;
  always #5 CLK = ~CLK;
  assign mem_rd = mem[mem_a[5:0]];
  always @(posedge CLK) begin
    if (mem_we) mem[mem_a[5:0]] <= mem_wd;
    else if (pl_we) mem[pl_a] <= pl_d;
  end
  lsu_subword_rmw dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall),
    .load_data(load_data), .misalign_err(misalign_err), .mem_we(mem_we), .mem_a(mem_a),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );
  task automatic poke(input logic [5:0] a, input logic [31:0] d);
    @(negedge CLK);
    req_valid = 1'b0; pl_we = 1'b1; pl_a = a; pl_d = d;
    @(negedge CLK);
    pl_we = 1'b0;
  endtask
  task automatic drive(input logic v, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    @(negedge CLK);
    req_valid = v; req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    #1;
  endtask
  task automatic hold();
    @(negedge CLK);
    #1;
  endtask
  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_misalign got=%b exp=0", misalign_err); end
    checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL reset_load_data got=%h exp=0", load_data); end
    checks++; if (dut.rd_q !== 32'h0) begin errors++; $display("FAIL reset_rd_q got=%h exp=0", dut.rd_q); end
    checks++; if (dut.state !== ST_IDLE) begin errors++; $display("FAIL reset_state got=%b exp=IDLE", dut.state); end
    @(negedge CLK);
    RST = 1'b0;
  endtask
  task automatic test_load();
    poke(6'd0, 32'h8765_4321);
    drive(1, 0, 2'b00, 0, 32'h3, 32'h0);
    checks++; if (load_data !== 32'hFFFF_FF87) begin errors++; $display("FAIL ld_byte_s got=%h exp=ffffff87", load_data); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ld_byte_stall got=%b exp=0", stall); end
    drive(1, 0, 2'b00, 1, 32'h3, 32'h0);
    checks++; if (load_data !== 32'h0000_0087) begin errors++; $display("FAIL ld_byte_u got=%h exp=00000087", load_data); end
    drive(1, 0, 2'b00, 0, 32'h1, 32'h0);
    checks++; if (load_data !== 32'h0000_0043) begin errors++; $display("FAIL ld_byte1_s got=%h exp=00000043", load_data); end
    drive(1, 0, 2'b01, 0, 32'h2, 32'h0);
    checks++; if (load_data !== 32'hFFFF_8765) begin errors++; $display("FAIL ld_half_s got=%h exp=ffff8765", load_data); end
    drive(1, 0, 2'b01, 1, 32'h2, 32'h0);
    checks++; if (load_data !== 32'h0000_8765) begin errors++; $display("FAIL ld_half_u got=%h exp=00008765", load_data); end
    drive(1, 0, 2'b01, 0, 32'h0, 32'h0);
    checks++; if (load_data !== 32'h0000_4321) begin errors++; $display("FAIL ld_half0 got=%h exp=00004321", load_data); end
    drive(1, 0, 2'b10, 1, 32'h100, 32'h0);
    checks++; if (load_data !== 32'h8765_4321) begin errors++; $display("FAIL ld_word_wrap got=%h exp=87654321", load_data); end
    checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL ld_word_wrap_a got=%h exp=0", mem_a); end
    drive(0, 0, 2'b10, 0, 32'h0, 32'h0);
    checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL idle_load_data got=%h exp=0", load_data); end
  endtask
  task automatic test_store_half();
    poke(6'd1, 32'hAABB_CCDD);
    drive(1, 1, 2'b01, 0, 32'h6, 32'hFFFF_1234);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sh_c0_stall got=%b exp=1", stall); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL sh_c0_we got=%b exp=0", mem_we); end
    hold();
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL sh_c1_we got=%b exp=1", mem_we); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sh_c1_stall got=%b exp=0", stall); end
    checks++; if (mem_a !== 32'h1) begin errors++; $display("FAIL sh_c1_a got=%h exp=1", mem_a); end
    checks++; if (mem_wd !== 32'h1234_CCDD) begin errors++; $display("FAIL sh_c1_wd got=%h exp=1234ccdd", mem_wd); end
    drive(0, 0, 2'b00, 0, 32'h0, 32'h0);
    checks++; if (dut.state !== ST_IDLE) begin errors++; $display("FAIL sh_c2_state got=%b exp=IDLE", dut.state); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL sh_c2_we got=%b exp=0", mem_we); end
    checks++; if (mem[1] !== 32'h1234_CCDD) begin errors++; $display("FAIL sh_mem got=%h exp=1234ccdd", mem[1]); end
  endtask
  task automatic test_store_word();
    drive(1, 1, 2'b10, 0, 32'h8, 32'hDEAD_BEEF);
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL sw_we got=%b exp=1", mem_we); end
    checks++; if (mem_a !== 32'h2) begin errors++; $display("FAIL sw_a got=%h exp=2", mem_a); end
    checks++; if (mem_wd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_wd got=%h exp=deadbeef", mem_wd); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sw_stall got=%b exp=0", stall); end
    drive(1, 0, 2'b10, 0, 32'h8, 32'h0);
    checks++; if (load_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_ld got=%h exp=deadbeef", load_data); end
  endtask
  task automatic test_misalign();
    poke(6'd4, 32'h5555_AAAA);
    drive(1, 0, 2'b01, 0, 32'h5, 32'h0);
    checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL mis_ld got=%h exp=0", load_data); end
    checks++; if (stall !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL mis_ld_ctl got=%b%b exp=00", stall, mem_we); end
    drive(0, 0, 2'b00, 0, 32'h0, 32'h0);
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL mis_ld_err got=%b exp=1", misalign_err); end
    hold();
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL mis_ld_err2 got=%b exp=0", misalign_err); end
    drive(1, 1, 2'b11, 0, 32'h10, 32'h1234_5678);
    checks++; if (stall !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL mis_st_ctl got=%b%b exp=00", stall, mem_we); end
    drive(0, 0, 2'b00, 0, 32'h0, 32'h0);
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL mis_st_err got=%b exp=1", misalign_err); end
    hold();
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL mis_st_err2 got=%b exp=0", misalign_err); end
    checks++; if (mem[4] !== 32'h5555_AAAA) begin errors++; $display("FAIL mis_mem got=%h exp=5555aaaa", mem[4]); end
    drive(1, 1, 2'b10, 0, 32'h12, 32'h1);
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL mis_sw_we got=%b exp=0", mem_we); end
    drive(0, 0, 2'b00, 0, 32'h0, 32'h0);
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL mis_sw_err got=%b exp=1", misalign_err); end
  endtask
  task automatic test_back_to_back();
    poke(6'd3, 32'h0);
    drive(1, 1, 2'b00, 0, 32'hC, 32'h0000_0011);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_s1 got=%b exp=1", stall); end
    hold();
    checks++; if (mem_we !== 1'b1 || mem_wd !== 32'h0000_0011) begin errors++; $display("FAIL b2b_w1 got=%b/%h exp=1/00000011", mem_we, mem_wd); end
    drive(1, 1, 2'b00, 0, 32'hD, 32'h0000_0022);
    checks++; if (stall !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL b2b_s2 got=%b%b exp=10", stall, mem_we); end
    hold();
    checks++; if (mem_we !== 1'b1 || mem_wd !== 32'h0000_2211) begin errors++; $display("FAIL b2b_w2 got=%b/%h exp=1/00002211", mem_we, mem_wd); end
    drive(0, 0, 2'b00, 0, 32'h0, 32'h0);
    checks++; if (mem[3] !== 32'h0000_2211) begin errors++; $display("FAIL b2b_mem got=%h exp=00002211", mem[3]); end
  endtask
  task automatic test_rst_in_write();
    poke(6'd5, 32'h0102_0304);
    drive(1, 1, 2'b00, 0, 32'h14, 32'h0000_00AA);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rstw_stall got=%b exp=1", stall); end
    @(negedge CLK);
    RST = 1'b1;
    #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rstw_we got=%b exp=0", mem_we); end
    @(negedge CLK);
    RST = 1'b0; req_valid = 1'b0;
    #1;
    checks++; if (dut.state !== ST_IDLE) begin errors++; $display("FAIL rstw_state got=%b exp=IDLE", dut.state); end
    checks++; if (stall !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL rstw_ctl got=%b%b exp=00", stall, mem_we); end
    checks++; if (mem[5] !== 32'h0102_0304) begin errors++; $display("FAIL rstw_mem got=%h exp=01020304", mem[5]); end
  endtask
  initial begin
    test_reset();
    test_load();
    test_store_half();
    test_store_word();
    test_misalign();
    test_back_to_back();
    test_rst_in_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu_subword_rmw.md
Name: lsu_subword_rmw

Overview:
- Load/store front-end between the MEM pipeline stage and the word-addressed data memory.
- Turns byte addresses plus access size into word indices.
- Loads: extracts and sign/zero-extends byte or halfword data.
- Sub-word stores: performs a two-cycle read-modify-write, stalling the pipeline for one cycle.
- Word loads and word stores pass through in a single cycle.

Parameters:
- DATA_W, 32, data and byte-address width; must be 32.
- DEPTH_LOG2, 6, log2 of memory depth in words; word index = addr[DEPTH_LOG2+1:2].

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- req_valid  in  1  MEM stage holds a load/store this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  DATA_W  byte address.
- req_wdata  in  DATA_W  store data, right-aligned.
- stall  out  1  freeze PC and IF/ID/EX/MEM registers this cycle.
- load_data  out  DATA_W  extended load result, combinational.
- misalign_err  out  1  one-cycle pulse on a misaligned or illegal-size request.
- mem_we  out  1  data memory write enable.
- mem_a  out  DATA_W  word index, zero-extended.
- mem_wd  out  DATA_W  data memory write data.
- mem_rd  in  DATA_W  data memory read data (asynchronous read of mem_a).

Behaviour:
- Reset state: FSM in IDLE; stall=0, mem_we=0, misalign_err=0, rd_q=0, addr_q=0.
- FSM states are IDLE and WRITE.
- mem_a:
  - IDLE: word index of req_addr.
  - WRITE: word index of latched addr_q.
- Misaligned request: half with addr[0]=1, word with addr[1:0]!=0, or size=11.
  - Register misalign_err=1 for the next cycle.
  - No write, no stall.
  - load_data=0.
  - FSM stays IDLE.
- Load, IDLE, aligned:
  - load_data valid in the same cycle (zero latency).
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - Extend per req_unsigned; word loads ignore req_unsigned.
  - No stall.
- Word store, IDLE, aligned: mem_we=1, mem_wd=req_wdata in the same cycle, no stall.
- Sub-word store, IDLE, aligned:
  - Assert stall=1 (combinational), mem_we=0.
  - At the edge, latch rd_q<=mem_rd, addr_q, size, and wdata; go to WRITE.
- WRITE:
  - mem_we=1, stall=0.
  - mem_wd = rd_q with the selected byte or halfword lane replaced by the low bits of the latched wdata.
  - Return to IDLE unconditionally; the held request is ignored in this cycle.
- Throughput: a sub-word store occupies 2 cycles; a back-to-back sub-word store starts RMW on the next IDLE cycle.
- Load results are never taken from rd_q; no store-to-load forwarding is needed because the write completes before the next request is accepted.
- req_valid=0: stall=0, mem_we=0, load_data=0; WRITE still completes if already entered.
- RST asserted while in WRITE: no write that cycle (mem_we forced 0), return to IDLE; the partial store is dropped.
- Address bits above DEPTH_LOG2+1 are ignored in the word index.

Decomposition:
- Package lsu_pkg:
  - size enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL).
  - state enum (ST_IDLE, ST_WRITE).
  - Misalignment check function.
- Sub-module lsu_lane_align, purely combinational:
  - Load extract/extend from (word, addr[1:0], size, unsigned).
  - Store merge from (old word, new data, addr[1:0], size).
  - Used by both the load path and the WRITE path.

Test Plan:
- Word 0x0 = 0x8765_4321. Load byte at addr 0x3, signed -> load_data=0xFFFF_FF87, stall=0. Repeat unsigned -> 0x0000_0087.
- Word 0x4 = 0xAABB_CCDD. Store half 0x1234 at addr 0x6 -> cycle 0: stall=1, mem_we=0. Cycle 1: mem_we=1, mem_a=1, mem_wd=0x1234_CCDD. Cycle 2: back in IDLE.
- Store word 0xDEAD_BEEF at addr 0x8 -> same cycle mem_we=1, mem_a=2, no stall. Load word at addr 0x8 next cycle -> 0xDEAD_BEEF.
- Load half at addr 0x5 -> next cycle misalign_err=1 for exactly 1 cycle, mem_we never high. Repeat with req_size=11 on a store -> same response.
- Two consecutive store-bytes (0x11 @0xC, 0x22 @0xD) on word 0x0000_0000 -> two stalls, then memory holds 0x0000_2211.
- Assert RST in the WRITE cycle of a byte store -> mem_we=0, state IDLE, memory word unchanged, stall=0.
